// File: rtl/alu_result_buffer.sv
// First-word-fall-through result FIFO behind the ALU mux, with per-entry status
// flags captured at push time and a saturating count of consumed results.
module alu_result_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               opcode,
    input  logic [WIDTH-1:0]         zout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [3:0]               out_opcode,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_parity,
    output logic                     out_cmp,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              result_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [3:0]       opcode;
        logic             zero;
        logic             neg;
        logic             parity;
        logic             cmp;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry_d;
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     count_q, count_d;
    logic            push;
    logic            pop;

    assign in_ready  = (level_q != LW'(DEPTH)) & ~flush;
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    // A pop coinciding with flush is discarded, so it never reaches the counter.
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_entry_d        = '0;
        wr_entry_d.data   = zout;
        wr_entry_d.opcode = opcode;
        wr_entry_d.zero   = (zout == '0);
        wr_entry_d.neg    = zout[WIDTH-1];
        wr_entry_d.parity = ^zout;
        wr_entry_d.cmp    = (opcode inside {4'd12, 4'd13, 4'd14}) && (zout != '0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        if (pop && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; empty-state outputs are gated to zero instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry_d;
    end

    assign head         = mem_q[rd_ptr_q];
    assign out_data     = out_valid ? head.data   : '0;
    assign out_opcode   = out_valid ? head.opcode : '0;
    assign out_zero     = out_valid & head.zero;
    assign out_neg      = out_valid & head.neg;
    assign out_parity   = out_valid & head.parity;
    assign out_cmp      = out_valid & head.cmp;
    assign level        = level_q;
    assign result_count = count_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized and directed bench for alu_result_buffer against a queue-based
// reference model of the buffer contents and pop count.
module tb_alu_result_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [7:0] zout = 8'h00;
    logic       in_ready, out_valid, out_zero, out_neg, out_parity, out_cmp;
    logic [7:0] out_data;
    logic [3:0] out_opcode;
    logic [2:0] level;
    logic [15:0] result_count;

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .zout(zout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_opcode(out_opcode),
        .out_zero(out_zero), .out_neg(out_neg),
        .out_parity(out_parity), .out_cmp(out_cmp),
        .level(level), .result_count(result_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] op;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_count = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        obs_in_ready, exp_in_ready;

    task automatic report(input string name, input longint unsigned act, input longint unsigned exp);
        n_bad++;
        $display("FAIL %s: observed %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] m_data();
        return (mq.size() != 0) ? mq[0].data : 8'h00;
    endfunction
    function automatic logic [3:0] m_op();
        return (mq.size() != 0) ? mq[0].op : 4'h0;
    endfunction
    function automatic logic m_zero();
        return (mq.size() != 0) && (mq[0].data == 0);
    endfunction
    function automatic logic m_neg();
        return (mq.size() != 0) && (mq[0].data >= 8'd128);
    endfunction
    function automatic logic m_par();
        int ones = 0;
        if (mq.size() == 0) return 1'b0;
        for (int b = 0; b < 8; b++) ones += int'(mq[0].data[b]);
        return (ones % 2) == 1;
    endfunction
    function automatic logic m_cmp();
        return (mq.size() != 0) && (mq[0].op >= 4'd12) && (mq[0].op <= 4'd14) && (mq[0].data != 0);
    endfunction

    // One clock: drive inputs, sample in_ready, cross the edge, advance the model.
    task automatic drive_cycle(input logic v, input logic [3:0] op, input logic [7:0] z,
                               input logic rdy, input logic fl);
        bit   do_push, do_pop;
        ent_t e;
        in_valid = v; opcode = op; zout = z; out_ready = rdy; flush = fl;
        #1;
        exp_in_ready = (mq.size() != DEPTH) && !fl;
        obs_in_ready = in_ready;
        do_push = v && exp_in_ready;
        do_pop  = (mq.size() != 0) && rdy && !fl;
        @(posedge clk); #1;
        if (fl) mq.delete();
        else begin
            if (do_pop) begin
                mq.delete(0);
                if (m_count < 65535) m_count++;
            end
            if (do_push) begin
                e.data = z; e.op = op;
                mq.push_back(e);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0)    report("reset_out_valid", out_valid, 0);
        n_cmp++; if (in_ready !== 1'b1)     report("reset_in_ready", in_ready, 1);
        n_cmp++; if (level !== 3'd0)        report("reset_level", level, 0);
        n_cmp++; if (result_count !== 16'd0) report("reset_count", result_count, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
            n_cmp++;
            if ({out_valid, out_data, out_opcode, out_zero, out_neg, out_parity, out_cmp, level, result_count} !== '0)
                report("idle_outputs", {out_valid, out_data, out_opcode, level, result_count}, 0);
        end
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 4'd1, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1)  report("single_valid", out_valid, 1);
        n_cmp++; if (out_data !== 8'h00)  report("single_data", out_data, 0);
        n_cmp++; if (out_opcode !== 4'd1) report("single_opcode", out_opcode, 1);
        n_cmp++; if ({out_zero, out_neg, out_parity, out_cmp} !== 4'b1000)
            report("single_flags", {out_zero, out_neg, out_parity, out_cmp}, 4'b1000);
        drive_cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (result_count !== 16'd1) report("single_count", result_count, 1);
        n_cmp++; if (out_valid !== 1'b0)     report("single_empty", out_valid, 0);
    endtask

    task automatic test_flags();
        drive_cycle(1'b1, 4'd12, 8'h01, 1'b0, 1'b0);
        n_cmp++; if ({out_zero, out_neg, out_parity, out_cmp} !== 4'b0011)
            report("flags_cmp12", {out_zero, out_neg, out_parity, out_cmp}, 4'b0011);
        drive_cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'd6, 8'h80, 1'b0, 1'b0);
        n_cmp++; if ({out_zero, out_neg, out_parity, out_cmp} !== 4'b0110)
            report("flags_neg80", {out_zero, out_neg, out_parity, out_cmp}, 4'b0110);
        drive_cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (result_count !== 16'd3) report("flags_count", result_count, 3);
    endtask

    task automatic test_fill_wrap();
        logic [7:0] exp_seq [6];
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'd2, 8'hA0 + 8'(i), 1'b0, 1'b0);
        n_cmp++; if (level !== 3'd4)   report("fill_level", level, 4);
        n_cmp++; if (in_ready !== 1'b0) report("fill_in_ready", in_ready, 0);
        drive_cycle(1'b1, 4'd2, 8'hEE, 1'b1, 1'b0);
        n_cmp++; if (obs_in_ready !== 1'b0) report("full_push_pop_ready", obs_in_ready, 0);
        n_cmp++; if (level !== 3'd3)   report("full_push_pop_level", level, 3);
        n_cmp++; if (out_data !== 8'hA1) report("full_head", out_data, 8'hA1);
        drive_cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'd2, 8'hA4, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd2, 8'hA5, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd2, 8'hA6, 1'b0, 1'b0);
        n_cmp++; if (obs_in_ready !== 1'b0) report("refill_reject", obs_in_ready, 0);
        exp_seq = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_data !== exp_seq[i]) report("wrap_order", out_data, exp_seq[i]);
            drive_cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++; if (out_valid !== 1'b0)     report("wrap_empty", out_valid, 0);
        n_cmp++; if (result_count !== 16'd9) report("wrap_count", result_count, 9);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[$];
        logic [15:0] cnt0;
        drive_cycle(1'b1, 4'd3, 8'hB0, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd3, 8'hB1, 1'b0, 1'b0);
        seq.push_back(8'hB0); seq.push_back(8'hB1);
        cnt0 = result_count;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (out_data !== seq[0]) report("b2b_order", out_data, seq[0]);
            seq.delete(0);
            seq.push_back(8'hC0 + 8'(i));
            drive_cycle(1'b1, 4'd3, 8'hC0 + 8'(i), 1'b1, 1'b0);
            n_cmp++; if (level !== 3'd2) report("b2b_level", level, 2);
        end
        n_cmp++; if (result_count !== cnt0 + 16'd10) report("b2b_count", result_count, cnt0 + 16'd10);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (out_data !== seq[0]) report("b2b_drain", out_data, seq[0]);
            seq.delete(0);
            drive_cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        logic [15:0] cnt0;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'd5, 8'hD0 + 8'(i), 1'b0, 1'b0);
        n_cmp++; if (level !== 3'd3) report("flush_pre_level", level, 3);
        cnt0 = result_count;
        drive_cycle(1'b1, 4'd5, 8'hEE, 1'b1, 1'b1);
        n_cmp++; if (obs_in_ready !== 1'b0)  report("flush_in_ready", obs_in_ready, 0);
        n_cmp++; if (level !== 3'd0)         report("flush_level", level, 0);
        n_cmp++; if (out_valid !== 1'b0)     report("flush_valid", out_valid, 0);
        n_cmp++; if (result_count !== cnt0)  report("flush_count", result_count, cnt0);
        drive_cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (level !== 3'd0)         report("flush_nothing_stored", level, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            n_cmp++; if (obs_in_ready !== exp_in_ready) report("rnd_in_ready", obs_in_ready, exp_in_ready);
            n_cmp++; if (level !== 3'(mq.size()))         report("rnd_level", level, mq.size());
            n_cmp++; if (out_valid !== (mq.size() != 0))  report("rnd_valid", out_valid, mq.size() != 0);
            n_cmp++; if (out_data !== m_data())           report("rnd_data", out_data, m_data());
            n_cmp++; if (out_opcode !== m_op())           report("rnd_opcode", out_opcode, m_op());
            n_cmp++; if ({out_zero, out_neg, out_parity, out_cmp} !== {m_zero(), m_neg(), m_par(), m_cmp()})
                report("rnd_flags", {out_zero, out_neg, out_parity, out_cmp}, {m_zero(), m_neg(), m_par(), m_cmp()});
            n_cmp++; if (result_count !== 16'(m_count))   report("rnd_count", result_count, m_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i <= DEPTH && mq.size() != 0; i++) drive_cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'd7, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) drive_cycle(1'b1, 4'd7, 8'(i), 1'b1, 1'b0);
        n_cmp++; if (result_count !== 16'hFFFF) report("sat_count", result_count, 16'hFFFF);
        n_cmp++; if (level !== 3'd1)            report("sat_level", level, 1);
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 4'd9, 8'h5A, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (level !== 3'd0)         report("areset_level", level, 0);
        n_cmp++; if (out_valid !== 1'b0)     report("areset_valid", out_valid, 0);
        n_cmp++; if (result_count !== 16'd0) report("areset_count", result_count, 0);
        n_cmp++; if (out_data !== 8'h00)     report("areset_data", out_data, 0);
        mq.delete();
        m_count = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive_cycle(1'b1, 4'd13, 8'h03, 1'b0, 1'b0);
        n_cmp++; if ({out_data, out_cmp, out_parity} !== {8'h03, 1'b1, 1'b0})
            report("areset_recover", {out_data, out_cmp, out_parity}, {8'h03, 1'b1, 1'b0});
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_fill_wrap();
        test_back_to_back();
        test_flush();
        test_random();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
